// File: rtl/serial_nibble_adder_ctrl_pkg.sv
// rtl/serial_nibble_adder_ctrl_pkg.sv - shared constants and FSM encoding for the serial nibble adder
package adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_nibble_adder_ctrl_if.sv
// rtl/serial_nibble_adder_ctrl_if.sv - operand/result handshake bundle; op exists only with SERIAL_SUB_EN
interface serial_nibble_adder_ctrl_if
  import adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SERIAL_SUB_EN
  logic         op;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carryout;
  logic         overflow;
  logic         busy;

  modport master (
    output in_valid, a, b, out_ready,
`ifdef SERIAL_SUB_EN
    output op,
`endif
    input  in_ready, out_valid, sum, carryout, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
`ifdef SERIAL_SUB_EN
    input  op,
`endif
    output in_ready, out_valid, sum, carryout, overflow, busy
  );

endinterface

// File: rtl/serial_nibble_adder_ctrl_nibble_add_slice.sv
// rtl/serial_nibble_adder_ctrl_nibble_add_slice.sv - combinational 4-bit ripple adder slice
module nibble_add_slice
  import adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                carryin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                carryout,
  output logic                c3
);

  logic [NIBBLE_W:0] w_c;

  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = carryin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign carryout = w_c[NIBBLE_W];
  assign c3       = w_c[NIBBLE_W-1];

endmodule

// File: rtl/serial_nibble_adder_ctrl.sv
// rtl/serial_nibble_adder_ctrl.sv - wide add sequenced through one nibble slice, LS nibble first
// Optional subtract (a - b) compiled in with SERIAL_SUB_EN.
module serial_nibble_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  serial_nibble_adder_ctrl_if.slave bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t               r_state;
  state_t               w_next;
  logic [W-1:0]         r_a_sh;
  logic [W-1:0]         r_b_sh;
  logic [W-1:0]         r_sum_sh;
  logic [W-1:0]         r_sum;
  logic                 r_carry;
  logic                 r_carryout;
  logic                 r_overflow;
  logic [IDX_W-1:0]     r_idx;

  logic                 w_in_ready;
  logic                 w_out_valid;
  logic                 w_busy;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_sub;
  logic                 w_sub_in;
  logic [NIBBLE_W-1:0]  w_b_nib;
  logic [NIBBLE_W-1:0]  w_s_nib;
  logic                 w_cout;
  logic                 w_c3;
  logic [W-1:0]         w_sum_next;

`ifdef SERIAL_SUB_EN
  logic r_sub;

  assign w_sub_in = (bus.op == OP_SUB);
  assign w_sub    = r_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
    end else if (w_accept) begin
      r_sub <= w_sub_in;
    end
  end
`else
  assign w_sub_in = 1'b0;
  assign w_sub    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = w_in_ready & bus.in_valid;
  assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);

  // Subtract is a + ~b + 1: invert each b nibble, carry seeded with 1 at accept.
  assign w_b_nib    = r_b_sh[NIBBLE_W-1:0] ^ {NIBBLE_W{w_sub}};
  assign w_sum_next = {w_s_nib, r_sum_sh[W-1:NIBBLE_W]};

  nibble_add_slice u_slice (
    .a        (r_a_sh[NIBBLE_W-1:0]),
    .b        (w_b_nib),
    .carryin  (r_carry),
    .sum      (w_s_nib),
    .carryout (w_cout),
    .c3       (w_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_carryout <= 1'b0;
      r_overflow <= 1'b0;
      r_idx      <= '0;
    end else if (w_accept) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_carry <= w_sub_in;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_a_sh   <= r_a_sh >> NIBBLE_W;
      r_b_sh   <= r_b_sh >> NIBBLE_W;
      r_sum_sh <= w_sum_next;
      r_carry  <= w_cout;
      r_idx    <= r_idx + 1'b1;
      if (w_last) begin
        r_sum      <= w_sum_next;
        r_carryout <= w_cout;
        r_overflow <= w_c3 ^ w_cout;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.sum       = r_sum;
  assign bus.carryout  = r_carryout;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_serial_nibble_adder_ctrl.sv
// tb/tb_serial_nibble_adder_ctrl.sv - self-checking bench for serial_nibble_adder_ctrl (NIBBLES = 4)
module tb_serial_nibble_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    int           hold;
    logic         noise;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  exp_t sbq[$];

  serial_nibble_adder_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  serial_nibble_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                         input int hold, input logic noise,
                         input logic [W-1:0] s, input logic c, input logic o);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.hold = hold; v.noise = noise;
    v.sum = s; v.cout = c; v.ovf = o;
    vecs.push_back(v);
  endtask

  task automatic stir(input logic noise);
    if (noise) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
    end
  endtask

  task automatic release_result(input int id);
    exp_t e;
    chk($sformatf("v%0d_out_valid", id), bus.out_valid, 1);
    chk($sformatf("v%0d_busy_done", id), bus.busy, 1);
    if (bus.out_valid) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL v%0d_scoreboard: got a result, expected none queued", id);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("v%0d_sum", id), bus.sum, e.sum);
        chk($sformatf("v%0d_carryout", id), bus.carryout, e.cout);
        chk($sformatf("v%0d_overflow", id), bus.overflow, e.ovf);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    exp_t e;
    int   lat;
    int   low;
    @(negedge clk);
    chk($sformatf("v%0d_idle_in_ready", id), bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a        = v.a;
    bus.b        = v.b;
`ifdef SERIAL_SUB_EN
    bus.op       = v.op;
`endif
    e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf;
    sbq.push_back(e);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.a         = W'($urandom);
    bus.b         = W'($urandom);
    bus.out_ready = (v.hold == 0);
    chk($sformatf("v%0d_busy_run", id), bus.busy, 1);
    lat = 0;
    low = 0;
    while (!bus.out_valid && lat < 20) begin
      if (!bus.in_ready) low++;
      stir(v.noise);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d_latency", id), lat, NIBBLES);
    for (int h = 0; h < v.hold; h++) begin
      if (!bus.in_ready) low++;
      chk($sformatf("v%0d_hold%0d_valid", id, h), bus.out_valid, 1);
      chk($sformatf("v%0d_hold%0d_sum", id, h), bus.sum, v.sum);
      chk($sformatf("v%0d_hold%0d_cout", id, h), bus.carryout, v.cout);
      chk($sformatf("v%0d_hold%0d_ovf", id, h), bus.overflow, v.ovf);
      stir(v.noise);
      @(negedge clk);
    end
    if (!bus.in_ready) low++;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    release_result(id);
    @(negedge clk);
    chk($sformatf("v%0d_out_valid_drop", id), bus.out_valid, 0);
    chk($sformatf("v%0d_back_in_ready", id), bus.in_ready, 1);
    chk($sformatf("v%0d_in_ready_low_cycles", id), low, NIBBLES + 1 + v.hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
`ifdef SERIAL_SUB_EN
    bus.op        = 1'b0;
`endif

    add_vec(16'h7FFF, 16'h0001, 1'b0,  0, 1'b0, 16'h8000, 1'b0, 1'b1);
    add_vec(16'hFFFF, 16'h0001, 1'b0,  0, 1'b0, 16'h0000, 1'b1, 1'b0);
    add_vec(16'h8000, 16'h8000, 1'b0,  0, 1'b0, 16'h0000, 1'b1, 1'b1);
    add_vec(16'h1234, 16'h1111, 1'b0, 10, 1'b0, 16'h2345, 1'b0, 1'b0);
    add_vec(16'h0F0F, 16'h00F1, 1'b0,  0, 1'b1, 16'h1000, 1'b0, 1'b0);
    add_vec(16'hFFFF, 16'hFFFF, 1'b0,  3, 1'b1, 16'hFFFE, 1'b1, 1'b0);
`ifdef SERIAL_SUB_EN
    add_vec(16'h0003, 16'h0005, 1'b1,  0, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    add_vec(16'h8000, 16'h0001, 1'b1,  2, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
    add_vec(16'h4000, 16'h4000, 1'b0,  0, 1'b0, 16'h8000, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_carryout", bus.carryout, 0);
    chk("rst_overflow", bus.overflow, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      run_vec(v, i);
    end

    // Each accept yields exactly one result even with input noise.
    repeat (3) begin
      @(negedge clk);
      chk("no_extra_result", bus.out_valid, 0);
    end
    chk("scoreboard_drained", sbq.size(), 0);

    // Reset two RUN cycles into an operation discards it.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 16'h00FF;
    bus.b        = 16'h0001;
`ifdef SERIAL_SUB_EN
    bus.op       = 1'b0;
`endif
    sbq.push_back('{16'h0100, 1'b0, 1'b0});
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", bus.out_valid, 0);
    chk("midrun_rst_sum", bus.sum, 0);
    chk("midrun_rst_in_ready", bus.in_ready, 1);
    chk("midrun_rst_busy", bus.busy, 0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NIBBLES + 2) begin
      @(negedge clk);
      chk("post_rst_no_result", bus.out_valid, 0);
    end
    v.a = 16'h0002; v.b = 16'h0003; v.op = 1'b0; v.hold = 0; v.noise = 1'b0;
    v.sum = 16'h0005; v.cout = 1'b0; v.ovf = 1'b0;
    run_vec(v, 99);
    chk("final_scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
